// File: rtl/demux_stream_n.sv
// ============================================================================
// Module   : demux_stream_n
// Brief    : Registered 1:N_CH valid/ready stream demultiplexer, routing by
//            explicit select or round-robin. Defining DEMUX_CNT_EN adds the
//            per-channel 16-bit accepted-beat counters on port beat_cnt.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_stream_n #(
    parameter int N_CH = 4,
    parameter int DW   = 8,
    localparam int SW  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [SW-1:0]        sel,
    input  logic [DW-1:0]        in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [N_CH*DW-1:0]   out_data,
    output logic [N_CH-1:0]      out_valid,
    input  logic [N_CH-1:0]      out_ready,
    output logic [SW-1:0]        rr_ptr,
    output logic                 err
`ifdef DEMUX_CNT_EN
    ,
    output logic [N_CH*16-1:0]   beat_cnt
`endif
);

    localparam logic [SW:0]   c_nch_limit = (SW+1)'(N_CH);
    localparam logic [SW-1:0] c_last_ch   = SW'(N_CH - 1);

    logic [SW-1:0]   w_tgt;
    logic            w_tgt_ok;
    logic            w_tgt_busy;
    logic            w_accept;
    logic [N_CH-1:0] w_load;

    logic [SW-1:0]   r_rr_ptr;
    logic            r_err;

    assign w_tgt    = mode ? r_rr_ptr : sel;
    assign w_tgt_ok = ({1'b0, w_tgt} < c_nch_limit);

    // An out-of-range target matches no channel, so it is never busy and the
    // beat is swallowed rather than stalling the producer.
    always_comb begin
        w_tgt_busy = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (w_tgt == SW'(k)) begin
                w_tgt_busy = out_valid[k] & ~out_ready[k];
            end
        end
    end

    assign in_ready = ~w_tgt_busy;
    assign w_accept = in_valid & in_ready;

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic          r_valid;
        logic [DW-1:0] r_data;

        assign w_load[k] = w_accept & w_tgt_ok & (w_tgt == SW'(k));

        // A load in the same cycle as a drain keeps the slot full.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_data  <= '0;
            end else begin
                r_valid <= w_load[k] | (r_valid & ~out_ready[k]);
                if (w_load[k]) begin
                    r_data <= in_data;
                end
            end
        end

        assign out_valid[k]           = r_valid;
        assign out_data[k*DW +: DW]   = r_data;

`ifdef DEMUX_CNT_EN
        logic [15:0] r_cnt;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= '0;
            end else if (w_load[k]) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end

        assign beat_cnt[k*16 +: 16] = r_cnt;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
            r_err    <= 1'b0;
        end else begin
            r_err <= w_accept & ~w_tgt_ok;
            if (w_accept & mode) begin
                r_rr_ptr <= (r_rr_ptr == c_last_ch) ? '0 : r_rr_ptr + SW'(1);
            end
        end
    end

    assign rr_ptr = r_rr_ptr;
    assign err    = r_err;

endmodule

`default_nettype wire

// File: tb/tb_demux_stream_n.sv
// ============================================================================
// Module   : tb_demux_stream_n
// Brief    : Self-checking bench for demux_stream_n (4-channel main instance,
//            3-channel instance for out-of-range select).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demux_stream_n;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int SW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic            mode;
    logic [SW-1:0]   sel;
    logic [DW-1:0]   in_data;
    logic            in_valid;
    logic            in_ready;
    logic [N*DW-1:0] out_data;
    logic [N-1:0]    out_valid;
    logic [N-1:0]    out_ready;
    logic [SW-1:0]   rr_ptr;
    logic            err;

    logic [1:0]      sel3;
    logic            in_valid3;
    logic            in_ready3;
    logic [3*DW-1:0] out_data3;
    logic [2:0]      out_valid3;
    logic [2:0]      out_ready3;
    logic [1:0]      rr_ptr3;
    logic            err3;

`ifdef DEMUX_CNT_EN
    logic [N*16-1:0] beat_cnt;
    logic [3*16-1:0] beat_cnt3;
`endif

    int vectors    = 0;
    int miscompares = 0;

    demux_stream_n #(.N_CH(N), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rr_ptr    (rr_ptr),
        .err       (err)
`ifdef DEMUX_CNT_EN
        ,
        .beat_cnt  (beat_cnt)
`endif
    );

    demux_stream_n #(.N_CH(3), .DW(DW)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel3),
        .in_data   (in_data),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .out_data  (out_data3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .rr_ptr    (rr_ptr3),
        .err       (err3)
`ifdef DEMUX_CNT_EN
        ,
        .beat_cnt  (beat_cnt3)
`endif
    );

    // Leaves the bench at a falling edge with reset released.
    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; in_valid3 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1; mode = 1'b0; sel = '0; in_valid = 1'b0; out_ready = '1;
        tick();
        vectors++;
        if (out_valid !== 4'b0000) begin miscompares++; $display("FAIL reset_valid: got %b want 0000", out_valid); end
        vectors++;
        if (out_data !== 32'h0) begin miscompares++; $display("FAIL reset_data: got %h want 0", out_data); end
        vectors++;
        if (rr_ptr !== 2'd0 || err !== 1'b0) begin miscompares++; $display("FAIL reset_rr_err: got rr=%0d err=%b want 0 0", rr_ptr, err); end
        rst = 1'b0;
    endtask

    task automatic test_sel_basic;
        do_reset();
        mode = 1'b0; sel = 2'd2; in_data = 8'hA5; in_valid = 1'b1; out_ready = '1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL sel_ready_pre: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 4'b0100) begin miscompares++; $display("FAIL sel_valid: got %b want 0100", out_valid); end
        vectors++;
        if (out_data[2*DW +: DW] !== 8'hA5) begin miscompares++; $display("FAIL sel_data: got %h want a5", out_data[2*DW +: DW]); end
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL sel_ready_post: got %b want 1", in_ready); end
        tick();
        vectors++;
        if (out_valid !== 4'b0000 || out_data[2*DW +: DW] !== 8'hA5) begin
            miscompares++; $display("FAIL sel_drain: got v=%b d=%h want 0000 a5", out_valid, out_data[2*DW +: DW]);
        end
    endtask

    task automatic test_backpressure;
        do_reset();
        mode = 1'b0; sel = 2'd1; out_ready = 4'b1101; in_data = 8'h11; in_valid = 1'b1;
        tick();
        in_data = 8'h22;
        #1;
        vectors++;
        if (out_valid[1] !== 1'b1 || out_data[DW +: DW] !== 8'h11) begin
            miscompares++; $display("FAIL bp_first: got v=%b d=%h want 1 11", out_valid[1], out_data[DW +: DW]);
        end
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_stall: got %b want 0", in_ready); end
        tick();
        vectors++;
        if (out_data[DW +: DW] !== 8'h11 || in_ready !== 1'b0) begin
            miscompares++; $display("FAIL bp_hold: got d=%h rdy=%b want 11 0", out_data[DW +: DW], in_ready);
        end
        out_ready = 4'b1111;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 4'b0010 || out_data[DW +: DW] !== 8'h22) begin
            miscompares++; $display("FAIL bp_second: got v=%b d=%h want 0010 22", out_valid, out_data[DW +: DW]);
        end
        tick();
        vectors++;
        if (out_valid !== 4'b0000) begin miscompares++; $display("FAIL bp_empty: got %b want 0000", out_valid); end
    endtask

    task automatic test_round_robin;
        logic [N-1:0] ev;
        do_reset();
        mode = 1'b1; out_ready = '1;
        for (int i = 0; i < 6; i++) begin
            in_data = 8'(i); in_valid = 1'b1;
            tick();
            ev = N'(1) << (i % N);
            vectors++;
            if (out_valid !== ev || out_data[(i % N)*DW +: DW] !== 8'(i)) begin
                miscompares++;
                $display("FAIL rr_beat%0d: got v=%b d=%h want %b %h", i, out_valid, out_data[(i % N)*DW +: DW], ev, 8'(i));
            end
        end
        in_valid = 1'b0;
        vectors++;
        if (rr_ptr !== 2'd2) begin miscompares++; $display("FAIL rr_end: got %0d want 2", rr_ptr); end
    endtask

    task automatic test_rr_stall;
        do_reset();
        mode = 1'b1; out_ready = '0;
        for (int i = 0; i < N; i++) begin
            in_data = 8'(8'h40 + i); in_valid = 1'b1;
            tick();
        end
        vectors++;
        if (out_valid !== 4'b1111 || rr_ptr !== 2'd0) begin
            miscompares++; $display("FAIL stall_full: got v=%b rr=%0d want 1111 0", out_valid, rr_ptr);
        end
        in_data = 8'h99;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_ready: got %b want 0", in_ready); end
        tick();
        vectors++;
        if (rr_ptr !== 2'd0 || out_data[DW-1:0] !== 8'h40) begin
            miscompares++; $display("FAIL stall_hold: got rr=%0d d0=%h want 0 40", rr_ptr, out_data[DW-1:0]);
        end
        out_ready = 4'b0001;
        tick();
        in_valid = 1'b0;
        vectors++;
        if (rr_ptr !== 2'd1 || out_data[DW-1:0] !== 8'h99 || out_valid !== 4'b1111) begin
            miscompares++; $display("FAIL stall_resume: got rr=%0d d0=%h v=%b want 1 99 1111", rr_ptr, out_data[DW-1:0], out_valid);
        end
    endtask

    task automatic test_reset_inflight;
        do_reset();
        mode = 1'b1; out_ready = '0; in_data = 8'h77; in_valid = 1'b1;
        tick();
        rst = 1'b1; in_data = 8'h88;
        tick();
        vectors++;
        if (out_valid !== 4'b0000 || out_data !== 32'h0 || rr_ptr !== 2'd0) begin
            miscompares++; $display("FAIL rst_inflight: got v=%b d=%h rr=%0d want 0 0 0", out_valid, out_data, rr_ptr);
        end
        rst = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_out_of_range;
        do_reset();
        mode = 1'b0; sel3 = 2'd3; in_data = 8'h5A; in_valid3 = 1'b1; out_ready3 = '0;
        #1;
        vectors++;
        if (in_ready3 !== 1'b1) begin miscompares++; $display("FAIL oor_ready: got %b want 1", in_ready3); end
        tick();
        in_valid3 = 1'b0;
        vectors++;
        if (err3 !== 1'b1 || out_valid3 !== 3'b000 || out_data3 !== 24'h0) begin
            miscompares++; $display("FAIL oor_drop: got err=%b v=%b d=%h want 1 000 0", err3, out_valid3, out_data3);
        end
        tick();
        vectors++;
        if (err3 !== 1'b0) begin miscompares++; $display("FAIL oor_pulse: got %b want 0", err3); end
        sel3 = 2'd2; in_valid3 = 1'b1;
        tick();
        in_valid3 = 1'b0;
        vectors++;
        if (err3 !== 1'b0 || out_valid3 !== 3'b100 || out_data3[2*DW +: DW] !== 8'h5A) begin
            miscompares++; $display("FAIL oor_inrange: got err=%b v=%b d=%h want 0 100 5a", err3, out_valid3, out_data3[2*DW +: DW]);
        end
    endtask

    // Reference: each channel is a one-slot buffer; drains first, then the
    // accepted beat (if any) fills its target slot.
    task automatic test_random;
        logic           m_full [N];
        logic [DW-1:0]  m_data [N];
        int             m_rr;
        logic           m_err;
        int             t;
        logic           exp_rdy;
        do_reset();
        for (int k = 0; k < N; k++) begin m_full[k] = 1'b0; m_data[k] = '0; end
        m_rr = 0; m_err = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < N; k++) begin
                vectors++;
                if (out_valid[k] !== m_full[k] || out_data[k*DW +: DW] !== m_data[k]) begin
                    miscompares++;
                    $display("FAIL rand_ch%0d cyc%0d: got v=%b d=%h want %b %h", k, c, out_valid[k], out_data[k*DW +: DW], m_full[k], m_data[k]);
                end
            end
            vectors++;
            if (rr_ptr !== 2'(m_rr) || err !== m_err) begin
                miscompares++; $display("FAIL rand_rr cyc%0d: got rr=%0d err=%b want %0d %b", c, rr_ptr, err, m_rr, m_err);
            end
            mode      = 1'($urandom_range(0, 1));
            sel       = 2'($urandom_range(0, 3));
            in_data   = 8'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = 4'($urandom_range(0, 15));
            #1;
            t = mode ? m_rr : int'(sel);
            exp_rdy = (t >= N) ? 1'b1 : (!m_full[t] || out_ready[t]);
            vectors++;
            if (in_ready !== exp_rdy) begin
                miscompares++; $display("FAIL rand_ready cyc%0d: got %b want %b", c, in_ready, exp_rdy);
            end
            m_err = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (m_full[k] && out_ready[k]) m_full[k] = 1'b0;
            end
            if (in_valid && exp_rdy) begin
                if (t < N) begin
                    m_full[t] = 1'b1;
                    m_data[t] = in_data;
                end else begin
                    m_err = 1'b1;
                end
                if (mode) m_rr = (m_rr + 1) % N;
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

`ifdef DEMUX_CNT_EN
    task automatic test_beat_count;
        do_reset();
        mode = 1'b0; sel = 2'd0; out_ready = '1; in_data = 8'h3C; in_valid = 1'b1;
        repeat (70000) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        vectors++;
        if (beat_cnt[15:0] !== 16'd4464 || beat_cnt[N*16-1:16] !== '0) begin
            miscompares++; $display("FAIL beat_cnt: got %h want ch0=%0d others 0", beat_cnt, 4464);
        end
    endtask
`endif

    initial begin
        rst = 1'b1; mode = 1'b0; sel = '0; in_data = '0; in_valid = 1'b0; out_ready = '0;
        sel3 = '0; in_valid3 = 1'b0; out_ready3 = '0;
        test_reset();
        test_sel_basic();
        test_backpressure();
        test_round_robin();
        test_rr_stall();
        test_reset_inflight();
        test_out_of_range();
        test_random();
`ifdef DEMUX_CNT_EN
        test_beat_count();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
